// File: rtl/if_fetch_redirect_if.sv
// Instruction-memory request/response bus used by the fetch unit.
// master = fetch side (drives req/addr), slave = memory side.
interface if_fetch_redirect_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_redirect.sv
// Fetch unit: owns the PC, fetches one instruction at a time, fills IF/ID and
// redirects on taken branches. Optional feature macro: IF_MISALIGN_TRAP_EN.
//
// state | meaning
// RESET | one cycle after reset release, no request
// REQ   | imem_req high at pc, waiting for gnt
// WAIT  | request granted, waiting for rvalid (drop_q discards it)
// HOLD  | response parked in the one-entry buffer while IF/ID is stalled
module if_fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       c_jump,
  input  logic [31:0]                jump_target,
  input  logic                       stall,
  if_fetch_redirect_if.master        imem,
  output logic                       if_valid,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_instr,
  output logic                       flush
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                       misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        flush_q, flush_d;
  logic        imem_req_q, imem_req_d;

  logic        redirect;
  logic [31:0] target_aligned;
  logic [31:0] pc_inc;

  always_comb begin
    redirect       = c_jump && !stall;
    target_aligned = jump_target & ~32'h0000_0003;
    pc_inc         = pc_q + 32'd4;

    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    flush_d     = redirect;

    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        // rvalid here can only be a leftover from before reset
        if (imem.imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (if_valid_q && stall) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = imem.imem_rdata;
            pc_d        = pc_inc;
            state_d     = S_HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem.imem_rdata;
            pc_d       = pc_inc;
            state_d    = S_REQ;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if_valid_d  = buf_valid_q;
          if_pc_d     = buf_pc_q;
          if_instr_d  = buf_instr_q;
          buf_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_RESET;
    endcase

    // Redirect overrides any IF/ID load decided above.
    if (redirect) begin
      pc_d        = target_aligned;
      if_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      if (state_q == S_REQ && imem.imem_gnt) begin
        drop_d = 1'b1;
      end
      if (state_q == S_HOLD) begin
        state_d = S_REQ;
      end
    end

    imem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      if_instr_q  <= 32'h0;
      flush_q     <= 1'b0;
      imem_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      flush_q     <= flush_d;
      imem_req_q  <= imem_req_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = redirect && (jump_target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`endif

  // imem_addr is pc_q itself, so it only moves on grant completion or redirect.
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign flush          = flush_q;

endmodule
